sodor5_commit_checker: RTL and testbench

- Receiving end of the instruction stream the sodor5 verification bench injects.
- Consumes the register-writeback (commit) streams of the 5-stage core and of the ISA reference model (s5m).
- Buffers each stream independently and compares them in program order.
- Raises sticky, diagnosable failure flags on the first data mismatch, a stream overflow or excessive lag.

---
 rtl/sodor5_commit_checker.sv | 218 +++++++++++++++++++++
 tb/tb_sodor5_commit_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor5_commit_checker.sv
// Commit-stream checker: buffers core and reference-model register writebacks
// and compares them pairwise in program order, latching the first failure.

module sodor5_commit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_empty_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_empty;
  logic             r_full;
  logic [OCC_W-1:0] w_occ_nxt;

  // Occupancy is the single source of truth for full/empty; pointers just wrap.
  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({i_push, i_pop})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_occ   <= w_occ_nxt;
      r_empty <= (w_occ_nxt == OCC_W'(0));
      r_full  <= (w_occ_nxt == OCC_W'(DEPTH));
    end
  end

  // Storage carries no reset; occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head_c      = r_mem[r_rd_ptr];
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_empty_nxt_c = (w_occ_nxt == OCC_W'(0));

endmodule

module sodor5_commit_checker #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_wb_valid,
  input  logic [4:0]       core_wb_rd,
  input  logic [31:0]      core_wb_data,
  input  logic             model_wb_valid,
  input  logic [4:0]       model_wb_rd,
  input  logic [31:0]      model_wb_data,
  output logic             mismatch,
  output logic             lag_error,
  output logic [4:0]       fail_rd,
  output logic [31:0]      fail_core_data,
  output logic [31:0]      fail_model_data,
  output logic [CNT_W-1:0] match_count,
  output logic             idle
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned ENT_W = RD_W + DAT_W;
  localparam int unsigned LAG_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_CHECK, ST_FAIL} state_t;

  state_t             r_state;
  logic               r_mismatch;
  logic               r_lag_error;
  logic [RD_W-1:0]    r_fail_rd;
  logic [DAT_W-1:0]   r_fail_core_data;
  logic [DAT_W-1:0]   r_fail_model_data;
  logic [CNT_W-1:0]   r_match_count;
  logic               r_idle;
  logic [LAG_W-1:0]   r_lag;

  logic               w_check;
  logic               w_core_req;
  logic               w_model_req;
  logic               w_core_push;
  logic               w_model_push;
  logic               w_core_ovf;
  logic               w_model_ovf;
  logic               w_pop;
  logic               w_differ;
  logic               w_match;
  logic               w_lag_inc;
  logic               w_timeout;
  logic               w_fail;
  logic [ENT_W-1:0]   w_core_head;
  logic [ENT_W-1:0]   w_model_head;
  logic               w_core_empty;
  logic               w_model_empty;
  logic               w_core_full;
  logic               w_model_full;
  logic               w_core_empty_nxt;
  logic               w_model_empty_nxt;

  sodor5_commit_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_core_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_core_push),
    .i_pop         (w_pop),
    .i_wdata       ({core_wb_rd, core_wb_data}),
    .o_head_c      (w_core_head),
    .o_empty       (w_core_empty),
    .o_full        (w_core_full),
    .o_empty_nxt_c (w_core_empty_nxt)
  );

  sodor5_commit_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_model_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_model_push),
    .i_pop         (w_pop),
    .i_wdata       ({model_wb_rd, model_wb_data}),
    .o_head_c      (w_model_head),
    .o_empty       (w_model_empty),
    .o_full        (w_model_full),
    .o_empty_nxt_c (w_model_empty_nxt)
  );

  // Writes to x0 are architecturally invisible and never enter the buffers.
  always_comb begin
    w_check      = (r_state == ST_CHECK);
    w_core_req   = w_check && core_wb_valid  && (core_wb_rd  != RD_W'(0));
    w_model_req  = w_check && model_wb_valid && (model_wb_rd != RD_W'(0));
    w_pop        = w_check && !w_core_empty && !w_model_empty;
    w_core_ovf   = w_core_req  && w_core_full  && !w_pop;
    w_model_ovf  = w_model_req && w_model_full && !w_pop;
    w_core_push  = w_core_req  && !w_core_ovf;
    w_model_push = w_model_req && !w_model_ovf;
    w_differ     = w_pop && (w_core_head != w_model_head);
    w_match      = w_pop && !w_differ;
    w_lag_inc    = w_check && (w_core_empty != w_model_empty);
    w_timeout    = w_lag_inc && (r_lag == LAG_W'(TIMEOUT - 1));
    w_fail       = w_differ || w_core_ovf || w_model_ovf || w_timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= ST_CHECK;
      r_mismatch        <= 1'b0;
      r_lag_error       <= 1'b0;
      r_fail_rd         <= '0;
      r_fail_core_data  <= '0;
      r_fail_model_data <= '0;
      r_match_count     <= '0;
      r_idle            <= 1'b1;
      r_lag             <= '0;
    end else begin
      unique case (r_state)
        ST_CHECK: begin
          if (w_lag_inc)
            r_lag <= r_lag + LAG_W'(1);
          else
            r_lag <= '0;
          if (w_match && (r_match_count != {CNT_W{1'b1}}))
            r_match_count <= r_match_count + CNT_W'(1);
          if (w_differ) begin
            r_mismatch        <= 1'b1;
            r_fail_rd         <= w_core_head[ENT_W-1:DAT_W];
            r_fail_core_data  <= w_core_head[DAT_W-1:0];
            r_fail_model_data <= w_model_head[DAT_W-1:0];
          end
          if (w_core_ovf || w_model_ovf || w_timeout)
            r_lag_error <= 1'b1;
          r_idle <= !w_fail && w_core_empty_nxt && w_model_empty_nxt;
          if (w_fail)
            r_state <= ST_FAIL;
        end
        // Terminal until reset: everything stays as captured.
        ST_FAIL: begin
          r_idle <= 1'b0;
        end
      endcase
    end
  end

  assign mismatch        = r_mismatch;
  assign lag_error       = r_lag_error;
  assign fail_rd         = r_fail_rd;
  assign fail_core_data  = r_fail_core_data;
  assign fail_model_data = r_fail_model_data;
  assign match_count     = r_match_count;
  assign idle            = r_idle;

endmodule

// File: tb/tb_sodor5_commit_checker.sv
// Bench for sodor5_commit_checker: directed table, corner-case sequences and
// randomized streams checked against a queue-based reference model.

module tb_sodor5_commit_checker;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 16;

  logic              clk;
  logic              reset;
  logic              core_wb_valid;
  logic [4:0]        core_wb_rd;
  logic [31:0]       core_wb_data;
  logic              model_wb_valid;
  logic [4:0]        model_wb_rd;
  logic [31:0]       model_wb_data;
  logic              mismatch;
  logic              lag_error;
  logic [4:0]        fail_rd;
  logic [31:0]       fail_core_data;
  logic [31:0]       fail_model_data;
  logic [CNT_W-1:0]  match_count;
  logic              idle;

  int n_checks = 0;
  int n_fail   = 0;

  sodor5_commit_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .core_wb_valid   (core_wb_valid),
    .core_wb_rd      (core_wb_rd),
    .core_wb_data    (core_wb_data),
    .model_wb_valid  (model_wb_valid),
    .model_wb_rd     (model_wb_rd),
    .model_wb_data   (model_wb_data),
    .mismatch        (mismatch),
    .lag_error       (lag_error),
    .fail_rd         (fail_rd),
    .fail_core_data  (fail_core_data),
    .fail_model_data (fail_model_data),
    .match_count     (match_count),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: two program-order queues and sticky failure bookkeeping.
  logic [36:0]      cq[$];
  logic [36:0]      mq[$];
  bit               m_failed;
  logic             m_mis;
  logic             m_lag_err;
  logic [4:0]       m_frd;
  logic [31:0]      m_fcd;
  logic [31:0]      m_fmd;
  logic [CNT_W-1:0] m_cnt;
  logic             m_idle;
  int               m_lag;

  task automatic model_reset();
    cq.delete();
    mq.delete();
    m_failed = 0; m_mis = 0; m_lag_err = 0;
    m_frd = 0; m_fcd = 0; m_fmd = 0; m_cnt = 0; m_idle = 1; m_lag = 0;
  endtask

  task automatic model_step();
    int csz, msz;
    bit pop, fail;
    logic [36:0] a, b;
    if (m_failed) return;
    csz = cq.size();
    msz = mq.size();
    pop = (csz > 0) && (msz > 0);
    fail = 0;
    if ((csz == 0) != (msz == 0)) begin
      m_lag++;
      if (m_lag >= TIMEOUT) begin m_lag_err = 1; fail = 1; end
    end else begin
      m_lag = 0;
    end
    if (pop) begin
      a = cq.pop_front();
      b = mq.pop_front();
      if (a != b) begin
        m_mis = 1; m_frd = a[36:32]; m_fcd = a[31:0]; m_fmd = b[31:0]; fail = 1;
      end else if (m_cnt != {CNT_W{1'b1}}) begin
        m_cnt++;
      end
    end
    if (core_wb_valid && core_wb_rd != 0) begin
      if (csz == DEPTH && !pop) begin m_lag_err = 1; fail = 1; end
      else cq.push_back({core_wb_rd, core_wb_data});
    end
    if (model_wb_valid && model_wb_rd != 0) begin
      if (msz == DEPTH && !pop) begin m_lag_err = 1; fail = 1; end
      else mq.push_back({model_wb_rd, model_wb_data});
    end
    m_failed = fail;
    m_idle = !fail && cq.size() == 0 && mq.size() == 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_mismatch"},   mismatch,        m_mis);
    chk({tag, "_lag_error"},  lag_error,       m_lag_err);
    chk({tag, "_fail_rd"},    fail_rd,         m_frd);
    chk({tag, "_fail_core"},  fail_core_data,  m_fcd);
    chk({tag, "_fail_model"}, fail_model_data, m_fmd);
    chk({tag, "_count"},      match_count,     m_cnt);
    chk({tag, "_idle"},       idle,            m_idle);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mismatch"},   mismatch,        0);
    chk({tag, "_lag_error"},  lag_error,       0);
    chk({tag, "_fail_rd"},    fail_rd,         0);
    chk({tag, "_fail_core"},  fail_core_data,  0);
    chk({tag, "_fail_model"}, fail_model_data, 0);
    chk({tag, "_count"},      match_count,     0);
    chk({tag, "_idle"},       idle,            1);
  endtask

  task automatic drive(input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    core_wb_valid = cv;  core_wb_rd = crd;  core_wb_data = cd;
    model_wb_valid = mv; model_wb_rd = mrd; model_wb_data = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic             cv;
    logic [4:0]       crd;
    logic [31:0]      cd;
    logic             mv;
    logic [4:0]       mrd;
    logic [31:0]      md;
    logic             e_mis;
    logic             e_lag;
    logic [CNT_W-1:0] e_cnt;
    logic             e_idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cv, logic [4:0] crd, logic [31:0] cd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic e_mis, logic e_lag, int e_cnt, logic e_idle);
    vec_t v;
    v.cv = cv; v.crd = crd; v.cd = cd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_mis = e_mis; v.e_lag = e_lag; v.e_cnt = CNT_W'(e_cnt); v.e_idle = e_idle;
    return v;
  endfunction

  function automatic logic [36:0] item(int unsigned i, int unsigned s);
    logic [31:0] d;
    d = 32'(i * 32'h9E3779B9) ^ 32'(s);
    return {5'(i % 31 + 1), d};
  endfunction

  task automatic gen_side(input int p, input int pcor, input int unsigned s,
                          inout int unsigned idx,
                          output logic v, output logic [4:0] rd, output logic [31:0] d);
    logic [36:0] it;
    if ($urandom_range(0, 99) < p) begin
      it = item(idx, s);
      idx++;
      v = 1; rd = it[36:32]; d = it[31:0];
      if ($urandom_range(0, 999) < pcor) d = d ^ 32'h1;
    end else if ($urandom_range(0, 99) < 5) begin
      v = 1; rd = 5'd0; d = $urandom;
    end else begin
      v = 0; rd = 5'($urandom); d = $urandom;
    end
  endtask

  int ep_pc [8] = '{70, 90, 100, 60, 95, 40, 100, 50};
  int ep_pm [8] = '{70, 90, 100, 80, 40, 95, 0,   50};
  int ep_cor[8] = '{0,  0,  0,   5,  0,  0,  0,   20};

  initial begin
    int unsigned seed, ci, mi;
    logic cv, mv;
    logic [4:0] crd, mrd;
    logic [31:0] cd, md;

    // Row table: equal stream, model-leading stream, x0 filtering, mismatch.
    for (int r = 0; r < 5; r++)
      tbl.push_back(mk(1, 5'(3 + r), 32'(32'h1000 + 3 + r), 1, 5'(3 + r), 32'(32'h1000 + 3 + r), 0, 0, r, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(k >= 3 && k < 9, 5'd1, 32'hA5A5A5A5, k < 6, 5'd1, 32'hA5A5A5A5,
                       0, 0, (k <= 3) ? 5 : 5 + (k - 3), k == 9));
    tbl.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 11, 1));
    tbl.push_back(mk(1, 2, 32'h2, 1, 2, 32'h2, 0, 0, 11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 1));
    tbl.push_back(mk(1, 5, 32'h11111111, 1, 5, 32'h11111112, 0, 0, 12, 0));
    tbl.push_back(mk(1, 9, 32'h9, 1, 9, 32'h9, 1, 0, 12, 0));
    tbl.push_back(mk(1, 10, 32'hA, 1, 10, 32'hA, 1, 0, 12, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 12, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_reset_vals("por");
    do_reset();
    check_reset_vals("rst");

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].crd, tbl[i].cd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      step();
      chk($sformatf("tbl%0d_mismatch", i), mismatch, tbl[i].e_mis);
      chk($sformatf("tbl%0d_lag", i), lag_error, tbl[i].e_lag);
      chk($sformatf("tbl%0d_count", i), match_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
    end
    chk("mis_fail_rd", fail_rd, 5);
    chk("mis_fail_core", fail_core_data, 32'h11111111);
    chk("mis_fail_model", fail_model_data, 32'h11111112);

    // Overflow: nine core pushes with a silent model.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'(i + 1), 32'(i), 0, 0, 0);
      step();
      chk($sformatf("ovf%0d_lag", i), lag_error, (i == 8));
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("ovf_mismatch", mismatch, 0);
    chk("ovf_fail_rd", fail_rd, 0);
    chk("ovf_fail_core", fail_core_data, 0);
    chk("ovf_count", match_count, 0);
    chk("ovf_idle", idle, 0);
    chk("ovf_lag_hold", lag_error, 1);

    // Timeout: one core entry, model never answers.
    do_reset();
    drive(1, 1, 32'h55, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 65; k++) begin
      step();
      if (k >= 62) chk($sformatf("to%0d_lag", k), lag_error, (k >= 64));
    end
    chk("to_mismatch", mismatch, 0);
    chk("to_idle", idle, 0);

    // Reset mid-wait discards the stale core entry.
    do_reset();
    drive(1, 1, 32'h77, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 30; k++) step();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    step();
    reset = 1'b0;
    drive(1, 4, 32'h44, 1, 4, 32'h44);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("postrst_count", match_count, 1);
    chk("postrst_mismatch", mismatch, 0);
    chk("postrst_lag", lag_error, 0);
    chk("postrst_idle", idle, 1);

    // Randomized episodes against the reference model.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      seed = $urandom;
      ci = 0;
      mi = 0;
      for (int c = 0; c < 250; c++) begin
        gen_side(ep_pc[ep], ep_cor[ep], seed, ci, cv, crd, cd);
        gen_side(ep_pm[ep], 0, seed, mi, mv, mrd, md);
        drive(cv, crd, cd, mv, mrd, md);
        model_step();
        step();
        check_model($sformatf("rnd%0d_%0d", ep, c));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
